serial_add_driver: RTL and testbench

//  Parallel front end for the bit-serial adder. Accepts a parallel operand pair

---
 rtl/serial_add_driver.sv | 177 +++++++++++++++++
 tb/tb_serial_add_driver.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_driver.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : serial_add_driver
//  Purpose  : Parallel front end for a bit-serial adder. Accepts an operand
//             pair plus carry-in on a valid/ready handshake, clears the adder,
//             shifts the operands out LSB first, collects the returned serial
//             sum bits and final carry, and presents them as a parallel result
//             on a second valid/ready handshake.
//  Ports    :
//     clk        in   1      rising-edge clock
//     reset      in   1      asynchronous, active-high reset
//     in_valid   in   1      operand pair valid
//     in_ready   out  1      driver idle, can accept operands
//     op_a       in   WIDTH  operand A
//     op_b       in   WIDTH  operand B
//     op_cin     in   1      carry-in for bit 0
//     adder_rst  out  1      reset to serial adder (clears its carry)
//     ser_a      out  1      serial operand A bit to adder
//     ser_b      out  1      serial operand B bit to adder
//     ser_cin    out  1      carry-in to adder (op_cin on bit 0 only)
//     ser_s      in   1      serial sum bit from adder
//     ser_cout   in   1      carry-out from adder
//     out_valid  out  1      result valid
//     out_ready  in   1      consumer accepts result
//     out_sum    out  WIDTH  parallel sum (modulo 2^WIDTH)
//     out_cout   out  1      final carry-out
//  Params   : WIDTH   operand/sum width (>= 2)
//             SUM_LAT adder latency from operand bit to sum bit (0 or 1)
//  Revision : 1.0  initial release
// ============================================================================
module serial_add_driver #(
   parameter int WIDTH   = 4,
   parameter int SUM_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic             adder_rst,
   output logic             ser_a,
   output logic             ser_b,
   output logic             ser_cin,
   input  logic             ser_s,
   input  logic             ser_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int               CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
   // A registered adder needs one extra cycle to return the last sum bit.
   localparam bit               HAS_DRAIN = (SUM_LAT != 0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             cin_q;
   logic             last_bit;
   logic             capture;
   logic             capture_last;

   assign last_bit  = (bit_cnt == LAST_BIT);
   assign adder_rst = reset | (state == ST_CLR);

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      ser_a        = 1'b0;
      ser_b        = 1'b0;
      ser_cin      = 1'b0;
      capture      = 1'b0;
      capture_last = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = ST_CLR;
            end
         end
         ST_CLR: begin
            state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            ser_a   = a_sh[0];
            ser_b   = b_sh[0];
            ser_cin = cin_q & (bit_cnt == '0);
            // With a registered adder the sum of bit i arrives during the
            // next cycle, so nothing valid is returned in shift cycle 0.
            capture      = !HAS_DRAIN || (bit_cnt != '0);
            capture_last = !HAS_DRAIN && last_bit;
            if (last_bit) begin
               state_nxt = HAS_DRAIN ? ST_DRAIN : ST_DONE;
            end
         end
         ST_DRAIN: begin
            capture      = 1'b1;
            capture_last = 1'b1;
            state_nxt    = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, operand shifters and result collection
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         cin_q    <= 1'b0;
         out_sum  <= '0;
         out_cout <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sh  <= op_a;
                  b_sh  <= op_b;
                  cin_q <= op_cin;
               end
            end
            ST_CLR: begin
               bit_cnt <= '0;
            end
            ST_SHIFT: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               bit_cnt <= bit_cnt + 1'b1;
            end
            default: begin
            end
         endcase
         // Sum bits arrive LSB first; shifting in from the MSB side leaves
         // bit 0 at out_sum[0] after WIDTH captures.
         if (capture) begin
            out_sum <= {ser_s, out_sum[WIDTH-1:1]};
         end
         if (capture_last) begin
            out_cout <= ser_cout;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_driver.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_driver
//  Purpose  : Self-checking bench for serial_add_driver. One DUT per adder
//             latency (SUM_LAT=0 and 1), each paired with a behavioural serial
//             adder. Expected results are queued when operands are driven and
//             compared when the result handshake completes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_driver;

   localparam int W = 4;

   logic clk = 1'b0;
   logic reset;

   logic [1:0]        in_valid, in_ready, op_cin, adder_rst;
   logic [1:0]        ser_a, ser_b, ser_cin, ser_s, ser_cout;
   logic [1:0]        out_valid, out_ready, out_cout;
   logic [1:0][W-1:0] op_a, op_b, out_sum;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;
   int cur      = 0;

   logic [W:0] exp_q[$];
   int         acc_q[$];
   int         vq[$];
   int         acc_cnt       = 0;
   int         out_cnt       = 0;
   int         last_acc_edge = 0;
   int         last_hs_edge  = 0;
   bit         ov_seen       = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------------------------------
   // DUTs and behavioural serial adders
   // ------------------------------------------------------------------------
   for (genvar L = 0; L < 2; L++) begin : g_lane
      logic       carry;
      logic [1:0] tot;

      serial_add_driver #(.WIDTH(W), .SUM_LAT(L)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (in_valid[L]),
         .in_ready  (in_ready[L]),
         .op_a      (op_a[L]),
         .op_b      (op_b[L]),
         .op_cin    (op_cin[L]),
         .adder_rst (adder_rst[L]),
         .ser_a     (ser_a[L]),
         .ser_b     (ser_b[L]),
         .ser_cin   (ser_cin[L]),
         .ser_s     (ser_s[L]),
         .ser_cout  (ser_cout[L]),
         .out_valid (out_valid[L]),
         .out_ready (out_ready[L]),
         .out_sum   (out_sum[L]),
         .out_cout  (out_cout[L])
      );

      assign tot = 2'(ser_a[L]) + 2'(ser_b[L]) + 2'(ser_cin[L]) + 2'(carry);
      always @(posedge clk) carry <= adder_rst[L] ? 1'b0 : tot[1];

      if (L == 0) begin : g_comb
         assign ser_s[L]    = tot[0];
         assign ser_cout[L] = tot[1];
      end else begin : g_reg
         logic s_q, co_q;
         always @(posedge clk) begin
            s_q  <= adder_rst[L] ? 1'b0 : tot[0];
            co_q <= adder_rst[L] ? 1'b0 : tot[1];
         end
         assign ser_s[L]    = s_q;
         assign ser_cout[L] = co_q;
      end
   end

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s lane=%0d t=%0t got=%0h exp=%0h", tag, cur, $time, got, exp);
      end
   endtask

   // Monitor: sampled on the falling edge, reports the rising edge that follows.
   initial begin : p_mon
      int         ae;
      logic [W:0] e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (in_valid[cur] && in_ready[cur]) begin
               acc_q.push_back(cyc + 1);
               acc_cnt++;
               last_acc_edge = cyc + 1;
            end
            if (out_valid[cur] && !ov_seen) begin
               ov_seen = 1'b1;
               vq.push_back(cyc + 1);
               if (acc_q.size() != 0) ae = acc_q.pop_front();
               else                   ae = -1000;
               check("latency", cyc + 1 - ae, W + 2 + cur);
            end
            if (out_valid[cur] && out_ready[cur]) begin
               if (exp_q.size() == 0) begin
                  check("spurious_result", out_valid[cur], 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_sum", out_sum[cur], e[W-1:0]);
                  check("out_cout", out_cout[cur], e[W]);
               end
               ov_seen      = 1'b0;
               out_cnt++;
               last_hs_edge = cyc + 1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] t;
      t = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      exp_q.push_back(t);
   endtask

   // Drives one operand pair and returns 1 time unit after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int n0;
      int guard;
      n0 = acc_cnt;
      op_a[cur]     = a;
      op_b[cur]     = b;
      op_cin[cur]   = c;
      in_valid[cur] = 1'b1;
      push_exp(a, b, c);
      guard = 0;
      while (acc_cnt == n0 && guard < 100) begin
         step();
         guard++;
      end
      check("accept_timeout", acc_cnt, n0 + 1);
      in_valid[cur] = 1'b0;
   endtask

   // As send, then follows the clear cycle and every shift cycle.
   task automatic send_trace(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      send(a, b, c);
      check("clr_adder_rst", adder_rst[cur], 1'b1);
      check("clr_ser_a", ser_a[cur], 1'b0);
      check("clr_ser_cin", ser_cin[cur], 1'b0);
      check("clr_in_ready", in_ready[cur], 1'b0);
      for (int i = 0; i < W; i++) begin
         step();
         check("shift_adder_rst", adder_rst[cur], 1'b0);
         check("shift_ser_a", ser_a[cur], a[i]);
         check("shift_ser_b", ser_b[cur], b[i]);
         check("shift_ser_cin", ser_cin[cur], (i == 0) ? c : 1'b0);
      end
      step();
      check("post_shift_ser_a", ser_a[cur], 1'b0);
   endtask

   task automatic wait_out(input int target);
      int guard;
      guard = 0;
      while (out_cnt < target && guard < 100) begin
         step();
         guard++;
      end
      check("result_timeout", out_cnt, target);
   endtask

   // ------------------------------------------------------------------------
   // Test sequence for the lane selected by cur
   // ------------------------------------------------------------------------
   task automatic run_lane();
      int base;
      int n0;
      int guard;

      out_ready[cur] = 1'b1;
      base = out_cnt;

      // Basic sums with serial trace
      send_trace(4'h5, 4'h3, 1'b1);
      wait_out(base + 1);
      send_trace(4'hF, 4'h1, 1'b0);
      wait_out(base + 2);
      send_trace(4'hF, 4'hF, 1'b1);
      wait_out(base + 3);

      // Back-pressure in DONE with a competing request
      out_ready[cur] = 1'b0;
      send(4'h1, 4'h2, 1'b0);
      guard = 0;
      while (!out_valid[cur] && guard < 50) begin
         step();
         guard++;
      end
      check("valid_timeout", out_valid[cur], 1'b1);
      n0 = acc_cnt;
      op_a[cur]     = 4'h6;
      op_b[cur]     = 4'h7;
      op_cin[cur]   = 1'b0;
      in_valid[cur] = 1'b1;
      push_exp(4'h6, 4'h7, 1'b0);
      repeat (5) begin
         step();
         check("hold_valid", out_valid[cur], 1'b1);
         check("hold_sum", out_sum[cur], 4'h3);
         check("hold_cout", out_cout[cur], 1'b0);
         check("hold_in_ready", in_ready[cur], 1'b0);
      end
      check("no_accept_in_done", acc_cnt, n0);
      out_ready[cur] = 1'b1;
      guard = 0;
      while (acc_cnt == n0 && guard < 20) begin
         step();
         guard++;
      end
      in_valid[cur] = 1'b0;
      check("accept_after_release", last_acc_edge, last_hs_edge + 1);
      wait_out(base + 5);

      // Reset in shift cycle 2
      send(4'h9, 4'h6, 1'b0);
      step();
      step();
      step();
      reset = 1'b1;
      #1;
      check("rst_adder_rst", adder_rst[cur], 1'b1);
      check("rst_out_valid", out_valid[cur], 1'b0);
      check("rst_in_ready", in_ready[cur], 1'b1);
      repeat (2) begin
         step();
         check("rst_hold_adder_rst", adder_rst[cur], 1'b1);
         check("rst_hold_valid", out_valid[cur], 1'b0);
      end
      reset = 1'b0;
      exp_q.delete();
      acc_q.delete();
      ov_seen = 1'b0;
      repeat (W + 4) begin
         step();
         check("no_partial_valid", out_valid[cur], 1'b0);
      end
      base = out_cnt;
      send(4'h2, 4'h2, 1'b0);
      wait_out(base + 1);

      // Three back-to-back operations
      vq.delete();
      base = out_cnt;
      n0   = acc_cnt;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin op_a[cur] = 4'h7; op_b[cur] = 4'h8; op_cin[cur] = 1'b1; end
            1:       begin op_a[cur] = 4'hA; op_b[cur] = 4'h3; op_cin[cur] = 1'b0; end
            default: begin op_a[cur] = 4'hC; op_b[cur] = 4'hC; op_cin[cur] = 1'b1; end
         endcase
         push_exp(op_a[cur], op_b[cur], op_cin[cur]);
         in_valid[cur] = 1'b1;
         guard = 0;
         while (acc_cnt != n0 + k + 1 && guard < 50) begin
            step();
            guard++;
         end
         check("b2b_accept_timeout", acc_cnt, n0 + k + 1);
      end
      in_valid[cur] = 1'b0;
      wait_out(base + 3);
      check("b2b_count", vq.size(), 3);
      if (vq.size() == 3) begin
         check("b2b_spacing_01", vq[1] - vq[0], W + 3 + cur);
         check("b2b_spacing_12", vq[2] - vq[1], W + 3 + cur);
      end
   endtask

   // ------------------------------------------------------------------------
   // Main
   // ------------------------------------------------------------------------
   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = '0;
      op_cin    = '0;
      op_a      = '0;
      op_b      = '0;
      repeat (3) step();
      for (int l = 0; l < 2; l++) begin
         cur = l;
         check("reset_out_valid", out_valid[l], 1'b0);
         check("reset_out_sum", out_sum[l], '0);
         check("reset_out_cout", out_cout[l], 1'b0);
         check("reset_ser_a", ser_a[l], 1'b0);
         check("reset_ser_cin", ser_cin[l], 1'b0);
         check("reset_adder_rst", adder_rst[l], 1'b1);
         check("reset_in_ready", in_ready[l], 1'b1);
      end
      reset = 1'b0;
      step();
      for (int l = 0; l < 2; l++) begin
         cur = l;
         check("idle_adder_rst", adder_rst[l], 1'b0);
      end
      for (int l = 0; l < 2; l++) begin
         cur = l;
         step();
         run_lane();
         repeat (3) step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
